reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  Register file and issue scoreboard that feeds the ALU and takes its write-back.
//  Accepts issue requests (src A, src B, dest), stalls on RAW/WAW hazards and reads operands.
//  Presents registered operands to the ALU stage over a valid/ready port.
//  Commits ALU results (write address + data) and clears the dest busy bit.
// PARAMETERS
//  DATA_W  8   register/operand width
//  NREG    16  number of registers; R0 reads 0 and is never written or busy
//  ADDR_W  4   register address width, $clog2(NREG)
// PORTS
//  clk          in   1       single clock, all logic on posedge
//  rst_n        in   1       synchronous active-low reset
//  iss_valid    in   1       issue request valid
//  iss_ready    out  1       issue accepted when iss_valid & iss_ready
//  iss_src_a    in   ADDR_W  source A register
//  iss_src_b    in   ADDR_W  source B register
//  iss_dest     in   ADDR_W  destination register (marked busy on accept; R0 ignored)
//  op_valid     out  1       operands valid toward ALU
//  op_ready     in   1       ALU stage consumes operands
//  op_a         out  DATA_W  operand A
//  op_b         out  DATA_W  operand B
//  op_dest      out  ADDR_W  dest carried to ALU as its write address
//  wb_valid     in   1       ALU result write-back valid (always accepted)
//  wb_addr      in   ADDR_W  write-back register
//  wb_data      in   DATA_W  write-back data (ALU out)
//  err_spurious out  1       sticky: write-back to a register that was not busy
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all registers 0, busy[] 0, op_valid 0, op_a/op_b/op_dest 0, err_spurious 0.
//  slot_free = !op_valid | op_ready.
//  hz(r) = busy[r] & (r!=0).
//  iss_ready = slot_free & !hz(src_a) & !hz(src_b) & !hz(dest). Combinational; no dependency on iss_valid.
//  Accept at edge N: op_a/op_b/op_dest load at N, op_valid=1 after N, busy[dest]=1 (dest!=0).
//  Issue-to-op latency is 1 cycle.
//  Operand read: regs[src] value before any same-edge write (read-before-write); R0 reads 0.
//  op_valid & !op_ready: op_* hold stable, iss_ready=0.
//  op_ready & !accept: op_valid falls next cycle.
//  op_ready & accept: back-to-back, 1 issue/cycle sustained.
//  Write-back (wb_valid, wb_addr!=0): regs[wb_addr]<=wb_data, busy[wb_addr]<=0.
//  wb_addr=0 is ignored entirely.
//  Write-back to a non-busy register still writes and sets err_spurious (cleared only by reset).
//  Same edge, accept dest==wb_addr: cannot occur without forwarding (dest busy stalls).
//  Same edge under forwarding: set wins, busy stays 1, data written.
//  Reset mid-operation: pending busy bits and op stage discarded; late write-backs after reset flag err_spurious.
// CONFIGURATION
//  SCB_FORWARD_EN defined:
//   - A register with wb_valid & wb_addr==r this cycle counts as not hazarded in iss_ready (src and dest).
//   - Matching sources take wb_data into op_a/op_b on the accept edge.
//   - Zero-bubble dependent issue.
//  SCB_FORWARD_EN undefined:
//   - Hazard clears one cycle after write-back; dependent issue waits >=1 extra cycle; no wb->op path.
// TESTING
//  Reset, then issue (a=1,b=2,d=3) with op_ready=1 -> op_valid next cycle, op_a=0, op_b=0, op_dest=3, busy[3]=1.
//  wb(3,0x5A) then issue (a=3,b=3,d=4) -> op_a=op_b=0x5A.
//   Without SCB_FORWARD_EN, issue in same cycle as wb -> iss_ready=0 that cycle.
//   With SCB_FORWARD_EN -> accepted same cycle, op_a=0x5A.
//  Issue d=5, then issue d=5 before wb -> iss_ready=0 (WAW) until wb(5) clears busy[5].
//  op_ready=0 for 3 cycles with op_valid=1 -> op_* stable, iss_ready=0.
//   op_ready=1 plus pending issue -> op updates next cycle, no bubble.
//  wb(7,0x11) with busy[7]=0 -> regs[7]=0x11, err_spurious=1 and stays 1.
//   wb(0,0xFF) -> R0 still reads 0.
//  rst_n=0 for one cycle while busy[3]=1 and op_valid=1 -> all outputs reset values, iss_ready=1 next cycle.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file with issue scoreboard: stalls RAW/WAW hazards, registers operands toward the ALU,
// commits write-backs. Optional write-back forwarding into issue is enabled by defining SCB_FORWARD_EN.
module reg_file_scoreboard #(
    parameter int DATA_W = 8,
    parameter int NREG   = 16,
    parameter int ADDR_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_src_a,
    input  logic [ADDR_W-1:0] iss_src_b,
    input  logic [ADDR_W-1:0] iss_dest,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_dest,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              err_spurious
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              op_valid_q, op_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [ADDR_W-1:0] op_dest_q, op_dest_d;
    logic              err_q, err_d;

    logic wb_we;
    logic slot_free;
    logic accept;
    logic hz_a, hz_b, hz_d;

`ifdef SCB_FORWARD_EN
    // A register being written back this cycle is treated as already free.
    function automatic logic hazard(input logic [NREG-1:0] busy, input logic [ADDR_W-1:0] r,
                                    input logic we, input logic [ADDR_W-1:0] wa);
        return busy[r] && (r != '0) && !(we && (wa == r));
    endfunction

    function automatic logic [DATA_W-1:0] read_op(input logic [DATA_W-1:0] rv,
                                                  input logic [ADDR_W-1:0] r, input logic we,
                                                  input logic [ADDR_W-1:0] wa,
                                                  input logic [DATA_W-1:0] wd);
        if (r == '0)
            return '0;
        else if (we && (wa == r))
            return wd;
        else
            return rv;
    endfunction

    assign hz_a = hazard(busy_q, iss_src_a, wb_we, wb_addr);
    assign hz_b = hazard(busy_q, iss_src_b, wb_we, wb_addr);
    assign hz_d = hazard(busy_q, iss_dest,  wb_we, wb_addr);
`else
    function automatic logic hazard(input logic [NREG-1:0] busy, input logic [ADDR_W-1:0] r);
        return busy[r] && (r != '0);
    endfunction

    // Read-before-write: same-edge write-back is not visible to the operand read.
    function automatic logic [DATA_W-1:0] read_op(input logic [DATA_W-1:0] rv,
                                                  input logic [ADDR_W-1:0] r);
        return (r == '0) ? '0 : rv;
    endfunction

    assign hz_a = hazard(busy_q, iss_src_a);
    assign hz_b = hazard(busy_q, iss_src_b);
    assign hz_d = hazard(busy_q, iss_dest);
`endif

    assign wb_we     = wb_valid && (wb_addr != '0);
    assign slot_free = !op_valid_q || op_ready;
    assign iss_ready = slot_free && !hz_a && !hz_b && !hz_d;
    assign accept    = iss_valid && iss_ready;

    always_comb begin
        busy_d     = busy_q;
        err_d      = err_q;
        op_valid_d = op_valid_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_dest_d  = op_dest_q;

        if (wb_we) begin
            busy_d[wb_addr] = 1'b0;
            if (!busy_q[wb_addr])
                err_d = 1'b1;
        end

        // Set after clear so a same-edge issue to the written register keeps it busy.
        if (accept) begin
            if (iss_dest != '0)
                busy_d[iss_dest] = 1'b1;
            op_valid_d = 1'b1;
`ifdef SCB_FORWARD_EN
            op_a_d = read_op(regs_q[iss_src_a], iss_src_a, wb_we, wb_addr, wb_data);
            op_b_d = read_op(regs_q[iss_src_b], iss_src_b, wb_we, wb_addr, wb_data);
`else
            op_a_d = read_op(regs_q[iss_src_a], iss_src_a);
            op_b_d = read_op(regs_q[iss_src_b], iss_src_b);
`endif
            op_dest_d = iss_dest;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_dest_q  <= '0;
        end else begin
            if (wb_we)
                regs_q[wb_addr] <= wb_data;
            busy_q     <= busy_d;
            err_q      <= err_d;
            op_valid_q <= op_valid_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_dest_q  <= op_dest_d;
        end
    end

    assign op_valid     = op_valid_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign op_dest      = op_dest_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard; follows SCB_FORWARD_EN when defined.
module tb_reg_file_scoreboard;

    localparam int DATA_W = 8;
    localparam int NREG   = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iss_valid;
    logic              iss_ready;
    logic [ADDR_W-1:0] iss_src_a, iss_src_b, iss_dest;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a, op_b;
    logic [ADDR_W-1:0] op_dest;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              err_spurious;

    int total = 0;
    int bad   = 0;

    reg_file_scoreboard #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src_a(iss_src_a), .iss_src_b(iss_src_b), .iss_dest(iss_dest),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dest(op_dest),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                         input logic [ADDR_W-1:0] d);
        iss_valid = 1'b1;
        iss_src_a = a;
        iss_src_b = b;
        iss_dest  = d;
        #1;
    endtask

    task automatic wb(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; iss_valid = 1'b0; iss_src_a = '0; iss_src_b = '0; iss_dest = '0;
        op_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        tick();
        tick();
        check_eq("rst_op_valid", op_valid, 0);
        check_eq("rst_op_a", op_a, 0);
        check_eq("rst_op_dest", op_dest, 0);
        check_eq("rst_err", err_spurious, 0);
        rst_n = 1'b1;

        // First issue: operands from reset register file.
        op_ready = 1'b1;
        issue(1, 2, 3);
        check_eq("iss1_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        check_eq("iss1_op_valid", op_valid, 1);
        check_eq("iss1_op_a", op_a, 0);
        check_eq("iss1_op_b", op_b, 0);
        check_eq("iss1_op_dest", op_dest, 3);

        // RAW on R3, then write-back of R3.
        issue(3, 3, 4);
        check_eq("raw_stall", iss_ready, 0);
        wb(3, 8'h5A);
`ifdef SCB_FORWARD_EN
        check_eq("raw_fwd_ready", iss_ready, 1);
        tick();
        wb_valid = 1'b0;
`else
        check_eq("raw_wb_cycle_ready", iss_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check_eq("raw_after_wb_ready", iss_ready, 1);
        tick();
`endif
        iss_valid = 1'b0;
        check_eq("raw_op_a", op_a, 8'h5A);
        check_eq("raw_op_b", op_b, 8'h5A);
        check_eq("raw_op_dest", op_dest, 4);
        check_eq("raw_err", err_spurious, 0);

        // WAW on R5.
        issue(0, 0, 5);
        check_eq("waw1_ready", iss_ready, 1);
        tick();
        issue(3, 0, 5);
        check_eq("waw_stall", iss_ready, 0);
        tick();
        check_eq("waw_stall2", iss_ready, 0);
        wb(5, 8'h33);
`ifdef SCB_FORWARD_EN
        check_eq("waw_fwd_ready", iss_ready, 1);
        tick();
        wb_valid = 1'b0;
`else
        check_eq("waw_wb_cycle_ready", iss_ready, 0);
        tick();
        wb_valid = 1'b0;
        #1;
        check_eq("waw_after_wb_ready", iss_ready, 1);
        tick();
`endif
        check_eq("waw_op_dest", op_dest, 5);
        check_eq("waw_op_a", op_a, 8'h5A);

        // ALU back-pressure: op stage holds and issue stalls.
        op_ready = 1'b0;
        issue(3, 3, 6);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_iss_ready", iss_ready, 0);
            tick();
            check_eq("bp_op_valid", op_valid, 1);
            check_eq("bp_op_dest", op_dest, 5);
            check_eq("bp_op_a", op_a, 8'h5A);
        end
        op_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        check_eq("b2b_op_valid", op_valid, 1);
        check_eq("b2b_op_dest", op_dest, 6);
        check_eq("b2b_op_b", op_b, 8'h5A);
        tick();
        check_eq("drain_op_valid", op_valid, 0);

        // Spurious write-back to idle R7, then R0 write ignored.
        wb(7, 8'h11);
        tick();
        wb_valid = 1'b0;
        check_eq("spur_err", err_spurious, 1);
        issue(7, 0, 0);
        check_eq("r7_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        check_eq("r7_op_a", op_a, 8'h11);
        wb(0, 8'hFF);
        tick();
        wb_valid = 1'b0;
        issue(0, 7, 0);
        tick();
        iss_valid = 1'b0;
        check_eq("r0_op_a", op_a, 0);
        check_eq("r0_op_b", op_b, 8'h11);
        tick();
        check_eq("spur_err_sticky", err_spurious, 1);

        // Reset while R3 busy and op stage full.
        op_ready = 1'b0;
        issue(0, 7, 3);
        tick();
        iss_valid = 1'b0;
        check_eq("pre_rst_op_valid", op_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_op_valid", op_valid, 0);
        check_eq("mid_rst_op_b", op_b, 0);
        check_eq("mid_rst_op_dest", op_dest, 0);
        check_eq("mid_rst_err", err_spurious, 0);
        issue(3, 3, 3);
        check_eq("mid_rst_ready", iss_ready, 1);
        iss_valid = 1'b0;
        issue(7, 0, 0);
        op_ready = 1'b1;
        tick();
        iss_valid = 1'b0;
        check_eq("mid_rst_r7", op_a, 0);
        wb(3, 8'h22);
        tick();
        wb_valid = 1'b0;
        check_eq("late_wb_err", err_spurious, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
